// File: rtl/timer_unit.sv
// Loadable timer/counter with strobe-source select, power-of-two prescaler,
// free-run / auto-reload / one-shot modes, compare strobe and sticky overflow flag.
module timer_unit #(
  parameter int WIDTH    = 8,
  parameter int PS_SEL_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                tick0,
  input  logic                tick1,
  input  logic                tick_sel,
  input  logic [PS_SEL_W-1:0] ps_sel,
  input  logic [1:0]          mode,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic [WIDTH-1:0]    reload_val,
  input  logic [WIDTH-1:0]    cmp_val,
  input  logic                ovf_clr,
  output logic [WIDTH-1:0]    tmr,
  output logic                ovf_pulse,
  output logic                ovf_flag,
  output logic                cmp_match,
  output logic                running
);

  localparam int PS_W  = (1 << PS_SEL_W) - 1;
  localparam int PS_W1 = PS_W + 1;

  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  // Terminal prescaler count for a divide ratio of 2^sel; computed one bit
  // wider so the largest exponent does not wrap before the subtraction.
  function automatic logic [PS_W-1:0] ps_limit(input logic [PS_SEL_W-1:0] sel);
    logic [PS_W1-1:0] pow;
    pow = PS_W1'(1) << sel;
    return PS_W'(pow - PS_W1'(1));
  endfunction

  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic [1:0]       md,
    input logic [WIDTH-1:0] rld
  );
    if (cur != '1)
      return cur + WIDTH'(1);
    else if (md == MODE_RELOAD)
      return rld;
    else
      return '0;
  endfunction

  logic [PS_W-1:0]  ps_cnt;
  logic             acc;
  logic             step;
  logic             ovf;
  logic [WIDTH-1:0] tmr_nxt;

  always_comb begin
    acc     = en & running & (tick_sel ? tick1 : tick0);
    step    = acc & (ps_cnt >= ps_limit(ps_sel));
    ovf     = step & (tmr == '1);
    tmr_nxt = next_count(tmr, mode, reload_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr       <= '0;
      ps_cnt    <= '0;
      ovf_pulse <= 1'b0;
      ovf_flag  <= 1'b0;
      cmp_match <= 1'b0;
      running   <= 1'b1;
    end else if (load) begin
      // A load overrides any step in the same cycle and re-arms the counter.
      tmr       <= load_val;
      ps_cnt    <= '0;
      running   <= 1'b1;
      ovf_pulse <= 1'b0;
      cmp_match <= 1'b0;
      if (ovf_clr)
        ovf_flag <= 1'b0;
    end else begin
      if (acc)
        ps_cnt <= step ? '0 : ps_cnt + PS_W'(1);
      if (step)
        tmr <= tmr_nxt;
      ovf_pulse <= ovf;
      cmp_match <= step & (tmr_nxt == cmp_val);
      if (ovf && mode == MODE_ONESHOT)
        running <= 1'b0;
      // Set beats clear when both land on the same edge.
      ovf_flag <= ovf | (ovf_flag & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_timer_unit.sv
// Directed testbench for timer_unit: per-feature tasks with hand-computed expectations.
module tb_timer_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       tick0;
  logic       tick1;
  logic       tick_sel;
  logic [2:0] ps_sel;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] reload_val;
  logic [7:0] cmp_val;
  logic       ovf_clr;
  logic [7:0] tmr;
  logic       ovf_pulse;
  logic       ovf_flag;
  logic       cmp_match;
  logic       running;

  int checks   = 0;
  int failures = 0;

  timer_unit #(.WIDTH(8), .PS_SEL_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .tick0      (tick0),
    .tick1      (tick1),
    .tick_sel   (tick_sel),
    .ps_sel     (ps_sel),
    .mode       (mode),
    .load       (load),
    .load_val   (load_val),
    .reload_val (reload_val),
    .cmp_val    (cmp_val),
    .ovf_clr    (ovf_clr),
    .tmr        (tmr),
    .ovf_pulse  (ovf_pulse),
    .ovf_flag   (ovf_flag),
    .cmp_match  (cmp_match),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    cyc();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++; if (tmr !== 8'h00) begin failures++; $display("FAIL rst_tmr got=%h exp=00", tmr); end
    checks++; if (ovf_pulse !== 1'b0) begin failures++; $display("FAIL rst_ovf_pulse got=%b exp=0", ovf_pulse); end
    checks++; if (ovf_flag !== 1'b0) begin failures++; $display("FAIL rst_ovf_flag got=%b exp=0", ovf_flag); end
    checks++; if (cmp_match !== 1'b0) begin failures++; $display("FAIL rst_cmp_match got=%b exp=0", cmp_match); end
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL rst_running got=%b exp=1", running); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_free_run();
    mode = 2'b00; ps_sel = 3'd0; tick_sel = 1'b0; cmp_val = 8'h80;
    do_load(8'hFD);
    checks++; if (tmr !== 8'hFD) begin failures++; $display("FAIL fr_load got=%h exp=FD", tmr); end
    tick0 = 1'b1;
    cyc();
    checks++; if (tmr !== 8'hFE || ovf_pulse !== 1'b0) begin failures++; $display("FAIL fr_fe got=%h/%b exp=FE/0", tmr, ovf_pulse); end
    cyc();
    checks++; if (tmr !== 8'hFF || ovf_pulse !== 1'b0) begin failures++; $display("FAIL fr_ff got=%h/%b exp=FF/0", tmr, ovf_pulse); end
    cyc();
    checks++; if (tmr !== 8'h00 || ovf_pulse !== 1'b1 || ovf_flag !== 1'b1) begin failures++; $display("FAIL fr_wrap got=%h/%b/%b exp=00/1/1", tmr, ovf_pulse, ovf_flag); end
    cyc();
    checks++; if (tmr !== 8'h01 || ovf_pulse !== 1'b0) begin failures++; $display("FAIL fr_after got=%h/%b exp=01/0", tmr, ovf_pulse); end
    tick0 = 1'b0;
    cyc();
    checks++; if (ovf_flag !== 1'b1) begin failures++; $display("FAIL fr_flag_sticky got=%b exp=1", ovf_flag); end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++; if (ovf_flag !== 1'b0) begin failures++; $display("FAIL fr_flag_clr got=%b exp=0", ovf_flag); end
  endtask

  task automatic test_prescale();
    mode = 2'b00;
    do_load(8'h00);
    tick_sel = 1'b1; ps_sel = 3'd2;
    for (int i = 0; i < 8; i++) begin
      tick1 = 1'b1; tick0 = 1'b0;
      cyc();
      tick1 = 1'b0; tick0 = 1'b1;
      cyc();
      if (i == 3) begin
        checks++; if (tmr !== 8'h01) begin failures++; $display("FAIL ps_half got=%h exp=01", tmr); end
      end
    end
    tick0 = 1'b0;
    checks++; if (tmr !== 8'h02) begin failures++; $display("FAIL ps_total got=%h exp=02", tmr); end
    tick_sel = 1'b0; ps_sel = 3'd0;
  endtask

  task automatic test_auto_reload();
    mode = 2'b01; reload_val = 8'hF0; cmp_val = 8'hF0;
    do_load(8'hFF);
    tick0 = 1'b1;
    cyc();
    tick0 = 1'b0;
    checks++; if (tmr !== 8'hF0) begin failures++; $display("FAIL ar_tmr got=%h exp=F0", tmr); end
    checks++; if (ovf_pulse !== 1'b1 || cmp_match !== 1'b1) begin failures++; $display("FAIL ar_strobes got=%b/%b exp=1/1", ovf_pulse, cmp_match); end
    cyc();
    checks++; if (ovf_pulse !== 1'b0 || cmp_match !== 1'b0 || ovf_flag !== 1'b1) begin failures++; $display("FAIL ar_after got=%b/%b/%b exp=0/0/1", ovf_pulse, cmp_match, ovf_flag); end
    cmp_val = 8'h33;
    do_load(8'h33);
    checks++; if (cmp_match !== 1'b0 || tmr !== 8'h33) begin failures++; $display("FAIL ar_load_eq_cmp got=%b/%h exp=0/33", cmp_match, tmr); end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    cmp_val = 8'h80;
  endtask

  task automatic test_one_shot();
    logic [7:0] exp_t [5] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       exp_r [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       exp_p [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    mode = 2'b10;
    do_load(8'hFE);
    tick0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (tmr !== exp_t[i] || running !== exp_r[i] || ovf_pulse !== exp_p[i]) begin
        failures++;
        $display("FAIL os_step%0d got=%h/%b/%b exp=%h/%b/%b", i, tmr, running, ovf_pulse, exp_t[i], exp_r[i], exp_p[i]);
      end
    end
    tick0 = 1'b0;
    do_load(8'h10);
    checks++; if (running !== 1'b1 || tmr !== 8'h10) begin failures++; $display("FAIL os_reload got=%b/%h exp=1/10", running, tmr); end
    tick0 = 1'b1;
    cyc();
    tick0 = 1'b0;
    checks++; if (tmr !== 8'h11) begin failures++; $display("FAIL os_resume got=%h exp=11", tmr); end
    mode = 2'b00;
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
  endtask

  task automatic test_simultaneous();
    mode = 2'b00; ps_sel = 3'd0;
    do_load(8'h20);
    load = 1'b1; load_val = 8'h40; tick0 = 1'b1;
    cyc();
    load = 1'b0;
    checks++; if (tmr !== 8'h40) begin failures++; $display("FAIL sim_load_step got=%h exp=40", tmr); end
    cyc();
    tick0 = 1'b0;
    checks++; if (tmr !== 8'h41) begin failures++; $display("FAIL sim_after_load got=%h exp=41", tmr); end
    cmp_val = 8'h00;
    do_load(8'hFF);
    tick0 = 1'b1; ovf_clr = 1'b1;
    cyc();
    tick0 = 1'b0; ovf_clr = 1'b0;
    checks++; if (ovf_flag !== 1'b1) begin failures++; $display("FAIL sim_set_wins got=%b exp=1", ovf_flag); end
    checks++; if (tmr !== 8'h00 || ovf_pulse !== 1'b1 || cmp_match !== 1'b1) begin failures++; $display("FAIL sim_wrap_cmp got=%h/%b/%b exp=00/1/1", tmr, ovf_pulse, cmp_match); end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++; if (ovf_flag !== 1'b0) begin failures++; $display("FAIL sim_clr got=%b exp=0", ovf_flag); end
    cmp_val = 8'h80;
  endtask

  task automatic test_reset_enable();
    mode = 2'b00; ps_sel = 3'd2;
    do_load(8'h55);
    tick0 = 1'b1;
    cyc();
    cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    checks++; if (tmr !== 8'h55) begin failures++; $display("FAIL en_hold got=%h exp=55", tmr); end
    en = 1'b1;
    cyc();
    checks++; if (tmr !== 8'h55) begin failures++; $display("FAIL en_ps_kept got=%h exp=55", tmr); end
    cyc();
    tick0 = 1'b0;
    checks++; if (tmr !== 8'h56) begin failures++; $display("FAIL en_resume got=%h exp=56", tmr); end
    ps_sel = 3'd0;
    do_load(8'hFF);
    tick0 = 1'b1;
    cyc();
    tick0 = 1'b0;
    ps_sel = 3'd2;
    do_load(8'h55);
    tick0 = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    checks++; if (tmr !== 8'h55 || ovf_flag !== 1'b1) begin failures++; $display("FAIL rs_pre got=%h/%b exp=55/1", tmr, ovf_flag); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (tmr !== 8'h00 || ovf_pulse !== 1'b0 || ovf_flag !== 1'b0 || cmp_match !== 1'b0 || running !== 1'b1) begin
      failures++;
      $display("FAIL rs_mid got=%h/%b/%b/%b/%b exp=00/0/0/0/1", tmr, ovf_pulse, ovf_flag, cmp_match, running);
    end
    for (int i = 0; i < 3; i++) cyc();
    checks++; if (tmr !== 8'h00) begin failures++; $display("FAIL rs_ps_cleared got=%h exp=00", tmr); end
    cyc();
    tick0 = 1'b0;
    checks++; if (tmr !== 8'h01) begin failures++; $display("FAIL rs_first_step got=%h exp=01", tmr); end
    ps_sel = 3'd0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; tick0 = 1'b0; tick1 = 1'b0; tick_sel = 1'b0;
    ps_sel = 3'd0; mode = 2'b00; load = 1'b0; load_val = 8'h00;
    reload_val = 8'h00; cmp_val = 8'h80; ovf_clr = 1'b0;
    test_reset();
    test_free_run();
    test_prescale();
    test_auto_reload();
    test_one_shot();
    test_simultaneous();
    test_reset_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
